// File: rtl/fpu_dispatch_q_pkg.sv
// Shared opcode, unit-select and FSM definitions for the FP dispatch queue.
package fpu_dispatch_q_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_FNEG   = 4'd4;
  localparam logic [3:0] OP_FMV    = 4'd5;
  localparam logic [3:0] OP_FABS   = 4'd6;
  localparam logic [3:0] OP_FSGNJ  = 4'd7;
  localparam logic [3:0] OP_FSGNJN = 4'd8;
  localparam logic [3:0] OP_FSGNJX = 4'd9;

  localparam logic [1:0] SEL_ADDSUB = 2'b00;
  localparam logic [1:0] SEL_MUL    = 2'b01;
  localparam logic [1:0] SEL_DIV    = 2'b10;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_unit_op(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  function automatic logic [1:0] op_unit_sel(input logic [3:0] op);
    logic [1:0] sel;
    sel = SEL_ADDSUB;
    if (op == OP_MUL) sel = SEL_MUL;
    if (op == OP_DIV) sel = SEL_DIV;
    return sel;
  endfunction

endpackage

// File: rtl/fpu_dispatch_q_if.sv
// Request/response valid-ready channels between the FP issue stage and the dispatch queue.
interface fpu_dispatch_q_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );
endinterface

// File: rtl/fpu_dispatch_q_req_fifo.sv
// In-order request FIFO; the head is exposed to the reader one cycle after it is written.
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   head_vld,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          head_vld_q;

  // Entries pushed on this edge are not counted for head_vld, so a fresh write
  // reaches the FSM one cycle later while a backlog drains without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_q + CW'(push) - CW'(pop);
      head_vld_q <= (count_q - CW'(pop)) != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout     = mem[rd_ptr];
  assign head_vld = head_vld_q;
  assign count    = count_q;

endmodule

// File: rtl/fpu_dispatch_q.sv
// Queued FP front-end: local sign-injection ops, dispatch of ADD/SUB/MUL/DIV to shared units, watchdog.
module fpu_dispatch_q
  import fpu_dispatch_q_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  fpu_dispatch_q_if.slave             bus,
  output logic                        unit_start,
  output logic [1:0]                  unit_sel,
  output logic                        unit_sub,
  output logic [31:0]                 unit_a,
  output logic [31:0]                 unit_b,
  input  logic                        unit_done,
  input  logic [31:0]                 unit_result,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int EW = 4 + 32 + 32 + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [EW-1:0]    fifo_din;
  logic [EW-1:0]    fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_vld;
  logic [3:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;
  logic [32:0]      local_res;

  state_t           state;
  logic [TW-1:0]    timer;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Returns {err, result}; unit opcodes never reach this path.
  function automatic logic [32:0] local_exec(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [32:0] r;
    r = {1'b1, FP_QNAN};
    case (op)
      OP_FNEG:   r = {1'b0, ~a[31], a[30:0]};
      OP_FMV:    r = {1'b0, a};
      OP_FABS:   r = {1'b0, 1'b0, a[30:0]};
      OP_FSGNJ:  r = {1'b0, b[31], a[30:0]};
      OP_FSGNJN: r = {1'b0, ~b[31], a[30:0]};
      OP_FSGNJX: r = {1'b0, a[31] ^ b[31], a[30:0]};
      default:   r = {1'b1, FP_QNAN};
    endcase
    return r;
  endfunction

  assign bus.req_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push     = bus.req_valid & bus.req_ready;
  assign fifo_din      = {bus.req_op, bus.req_a, bus.req_b, bus.req_tag};
  assign fifo_pop      = (state == ST_IDLE) & head_vld;
  assign {head_op, head_a, head_b, head_tag} = fifo_head;
  assign local_res     = local_exec(head_op, head_a, head_b);

  fpu_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .din      (fifo_din),
    .pop      (fifo_pop),
    .dout     (fifo_head),
    .head_vld (head_vld),
    .count    (fifo_count)
  );

  // Dispatch FSM: head pop -> (ISSUE -> WAIT) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      unit_start   <= 1'b0;
      unit_sel     <= SEL_ADDSUB;
      unit_sub     <= 1'b0;
      unit_a       <= '0;
      unit_b       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (head_vld) begin
            rsp_tag_q <= head_tag;
            if (is_unit_op(head_op)) begin
              unit_a     <= head_a;
              unit_b     <= head_b;
              unit_sel   <= op_unit_sel(head_op);
              unit_sub   <= (head_op == OP_SUB);
              unit_start <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              rsp_err_q    <= local_res[32];
              rsp_result_q <= local_res[31:0];
              rsp_valid_q  <= 1'b1;
              state        <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          unit_start <= 1'b0;
          timer      <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (unit_done) begin
            rsp_result_q <= unit_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= ST_RESP;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            rsp_result_q <= FP_QNAN;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_fpu_dispatch_q.sv
// Directed and randomized bench for fpu_dispatch_q against a queue-based reference model.
module tb_fpu_dispatch_q;

  localparam int NRAND = 40;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        unit_start, unit_sub, unit_done, busy;
  logic [1:0]  unit_sel;
  logic [31:0] unit_a, unit_b, unit_result;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_dispatch_q_if #(.TAG_W(4)) bus ();

  fpu_dispatch_q #(
    .FIFO_DEPTH  (4),
    .TAG_W       (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .unit_start  (unit_start),
    .unit_sel    (unit_sel),
    .unit_sub    (unit_sub),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Stand-in arithmetic unit: result is a fixed scramble of what it was started with.
  function automatic logic [31:0] unit_fn(input logic [1:0] sel, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]} ^ {sel, sub, 29'h0};
  endfunction

  // Reference behaviour of one request: {err, result}.
  function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0: return {1'b0, unit_fn(2'b00, 1'b0, a, b)};
      4'd1: return {1'b0, unit_fn(2'b00, 1'b1, a, b)};
      4'd2: return {1'b0, unit_fn(2'b01, 1'b0, a, b)};
      4'd3: return {1'b0, unit_fn(2'b10, 1'b0, a, b)};
      4'd4: return {1'b0, ~a[31], a[30:0]};
      4'd5: return {1'b0, a};
      4'd6: return {2'b00, a[30:0]};
      4'd7: return {1'b0, b[31], a[30:0]};
      4'd8: return {1'b0, ~b[31], a[30:0]};
      4'd9: return {1'b0, a[31] ^ b[31], a[30:0]};
      default: return {1'b1, QNAN};
    endcase
  endfunction

  int          unit_lat  = 5;
  logic        force_en  = 1'b0;
  logic [31:0] force_val = '0;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [31:0] model_res  = '0;
  int          ucnt = 0;
  bit          upend = 1'b0;
  logic [1:0]  usel;
  logic        usub;
  logic [31:0] ua, ub;

  assign unit_done   = model_done | stray_done;
  assign unit_result = model_res;

  always begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (rst === 1'b1) begin
      upend = 1'b0;
    end else if (unit_start === 1'b1) begin
      usel  = unit_sel;
      usub  = unit_sub;
      ua    = unit_a;
      ub    = unit_b;
      ucnt  = (unit_lat < 0) ? int'($urandom_range(1, 6)) : unit_lat;
      upend = (ucnt > 0);
    end else if (upend) begin
      ucnt--;
      if (ucnt == 0) begin
        model_done = 1'b1;
        model_res  = force_en ? force_val : unit_fn(usel, usub, ua, ub);
        upend      = 1'b0;
      end
    end
  end

  int start_cnt = 0;
  int rspv_cnt  = 0;
  always @(negedge clk) begin
    if (unit_start === 1'b1) start_cnt++;
    if (bus.rsp_valid === 1'b1) rspv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 300 && !bus.req_ready; k++) tick();
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int waited);
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic take(input string name, input logic [31:0] res, input logic [3:0] tag,
                      input logic err);
    int w;
    bus.rsp_ready = 1'b1;
    wait_rsp(w);
    chk({name, "_result"}, bus.rsp_result, res);
    chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
    chk({name, "_err"}, 32'(bus.rsp_err), 32'(err));
    tick();
  endtask

  logic [36:0] expq[$];

  initial begin
    logic [31:0] fmv_a [5];
    int          w;
    int          n;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_unit_start", 32'(unit_start), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    rst = 1'b0;

    // ADD through the unit, start-pulse timing and width
    unit_lat  = 5;
    force_en  = 1'b1;
    force_val = 32'h4100_0000;
    start_cnt = 0;
    bus.req_op = 4'd0; bus.req_a = 32'h40C0_0000; bus.req_b = 32'h4000_0000;
    bus.req_tag = 4'd3; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("add_start_n", 32'(unit_start), 32'd0);
    tick();
    chk("add_start_n1", 32'(unit_start), 32'd0);
    tick();
    chk("add_start_n2", 32'(unit_start), 32'd1);
    chk("add_sel", 32'(unit_sel), 32'd0);
    chk("add_sub", 32'(unit_sub), 32'd0);
    chk("add_unit_a", unit_a, 32'h40C0_0000);
    chk("add_unit_b", unit_b, 32'h4000_0000);
    tick();
    chk("add_start_drop", 32'(unit_start), 32'd0);
    take("add", 32'h4100_0000, 4'd3, 1'b0);
    chk("add_start_count", 32'(start_cnt), 32'd1);
    force_en = 1'b0;

    // FNEG latency: response after the second edge
    start_cnt = 0;
    bus.rsp_ready = 1'b1;
    bus.req_op = 4'd4; bus.req_a = 32'h4040_0000; bus.req_b = 32'h0;
    bus.req_tag = 4'd1; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("fneg_valid_n1", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("fneg_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("fneg_result", bus.rsp_result, 32'hC040_0000);
    chk("fneg_err", 32'(bus.rsp_err), 32'd0);
    tick();
    chk("fneg_no_start", 32'(start_cnt), 32'd0);

    send(4'd9, 32'hC040_0000, 32'hC000_0000, 4'd5);
    take("fsgnjx", 32'h4040_0000, 4'd5, 1'b0);
    send(4'd8, 32'h3FC0_0000, 32'h0000_0000, 4'd6);
    take("fsgnjn", 32'hBFC0_0000, 4'd6, 1'b0);

    // Fill with five FMVs while the consumer stalls, then drain in order
    bus.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      fmv_a[t] = $urandom;
      send(4'd5, fmv_a[t], $urandom, 4'(t));
    end
    tick();
    tick();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      wait_rsp(w);
      if (t == 0) chk("drain_ready_low", 32'(bus.req_ready), 32'd0);
      else        chk("drain_bubble", 32'(w), 32'd1);
      chk("drain_tag", 32'(bus.rsp_tag), 32'(t));
      chk("drain_result", bus.rsp_result, fmv_a[t]);
      tick();
    end

    // DIV that never completes: watchdog fires 64 cycles into WAIT
    unit_lat = 0;
    bus.rsp_ready = 1'b0;
    send(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7);
    for (int k = 0; k < 20 && unit_start !== 1'b1; k++) tick();
    chk("div_start", 32'(unit_start), 32'd1);
    chk("div_sel", 32'(unit_sel), 32'd2);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd65);
    chk("timeout_unit_a", unit_a, 32'h1234_5678);
    chk("timeout_result", bus.rsp_result, QNAN);
    chk("timeout_err", 32'(bus.rsp_err), 32'd1);
    chk("timeout_tag", 32'(bus.rsp_tag), 32'd7);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    tick();
    chk("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);

    send(4'hF, $urandom, $urandom, 4'd9);
    take("illegal", QNAN, 4'd9, 1'b1);

    // Reset in the middle of a MUL with another request queued behind it
    bus.rsp_ready = 1'b1;
    send(4'd2, 32'h3F80_0000, 32'h4000_0000, 4'd10);
    for (int k = 0; k < 20 && unit_start !== 1'b1; k++) tick();
    chk("mul_start", 32'(unit_start), 32'd1);
    send(4'd5, 32'hDEAD_BEEF, 32'h0, 4'd11);
    tick();
    chk("mul_queued", 32'(fifo_count), 32'd1);
    rspv_cnt = 0;
    rst = 1'b1;
    tick();
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("mrst_unit_start", 32'(unit_start), 32'd0);
    rst = 1'b0;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (80) tick();
    chk("mrst_no_response", 32'(rspv_cnt), 32'd0);
    chk("mrst_idle_busy", 32'(busy), 32'd0);

    // Randomized traffic with random unit latency and consumer back-pressure
    unit_lat = -1;
    bus.rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          logic [3:0]  op;
          logic [31:0] a, b;
          logic [32:0] r;
          op = 4'($urandom_range(0, 15));
          a  = $urandom;
          b  = $urandom;
          repeat ($urandom_range(0, 2)) tick();
          send(op, a, b, 4'(i));
          r = ref_op(op, a, b);
          expq.push_back({r[32], 4'(i), r[31:0]});
        end
      end
      begin
        for (int i = 0; i < NRAND; i++) begin
          int          guard;
          logic [36:0] e;
          guard = 0;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
          while (!(bus.rsp_valid === 1'b1 && bus.rsp_ready) && guard < 400) begin
            tick();
            guard++;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
          end
          chk("rand_handshake", 32'(bus.rsp_valid & bus.rsp_ready), 32'd1);
          if (bus.rsp_valid !== 1'b1) break;
          e = (expq.size() != 0) ? expq.pop_front() : 'x;
          chk("rand_result", bus.rsp_result, e[31:0]);
          chk("rand_tag", 32'(bus.rsp_tag), 32'(e[35:32]));
          chk("rand_err", 32'(bus.rsp_err), 32'(e[36]));
          tick();
        end
        bus.rsp_ready = 1'b0;
      end
    join
    tick();
    chk("rand_end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
